// File: rtl/scanchain_writer_if.sv
// scanchain_writer_if: write handshake bundle (valid/ready plus addr, payload and reset-phase request)
interface scanchain_writer_if #(
  parameter int ADDR_W = 12,
  parameter int PAYLOAD_W = 169
);
  logic                 write_valid;
  logic                 write_ready;
  logic                 write_reset;
  logic [ADDR_W-1:0]    write_addr;
  logic [PAYLOAD_W-1:0] write_payload;
  modport master (output write_valid, write_reset, write_addr, write_payload, input write_ready);
  modport slave (input write_valid, write_reset, write_addr, write_payload, output write_ready);
endinterface

// File: rtl/scanchain_writer.sv
// scanchain_writer: serialises one accepted write (ports clk, reset, bus slave; scan_clk/en/in/update/reset out) as reset, shift, update phases
module scanchain_writer #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int SCAN_CLK_FREQ = 1_000_000,
  parameter int ADDR_W = 12,
  parameter int PAYLOAD_W = 169
) (
  input  logic              clk,
  input  logic              reset,
  scanchain_writer_if.slave bus,
  output logic              scan_clk,
  output logic              scan_en,
  output logic              scan_in,
  output logic              scan_update,
  output logic              scan_reset
);
  localparam int HALF = CLOCK_FREQ / (2 * SCAN_CLK_FREQ);
  localparam int FRAME_W = ADDR_W + PAYLOAD_W;
  localparam int DIV_W = HALF > 1 ? $clog2(HALF) : 1;
  typedef enum logic [1:0] {IDLE, RST, SHIFT, UPDATE} state_t;
  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_cnt;
  logic [7:0]         r_bits;
  logic [FRAME_W-1:0] r_frame;
  logic               r_ready;
  logic               r_scan_clk;
  logic               r_scan_en;
  logic               r_scan_in;
  logic               r_scan_update;
  logic               r_scan_reset;
  logic               w_tick;
  assign w_tick = r_div == DIV_W'(HALF - 1);
  assign bus.write_ready = r_ready;
  assign scan_clk = r_scan_clk;
  assign scan_en = r_scan_en;
  assign scan_in = r_scan_in;
  assign scan_update = r_scan_update;
  assign scan_reset = r_scan_reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_div <= '0;
      r_cnt <= '0;
      r_bits <= '0;
      r_frame <= '0;
      r_ready <= 1'b1;
      r_scan_clk <= 1'b0;
      r_scan_en <= 1'b0;
      r_scan_in <= 1'b0;
      r_scan_update <= 1'b0;
      r_scan_reset <= 1'b0;
    end else begin
      r_div <= (r_state == IDLE || w_tick) ? '0 : r_div + 1'b1;
      case (r_state)
        IDLE: if (bus.write_valid) begin
          r_frame <= {bus.write_payload, bus.write_addr};
          r_ready <= 1'b0;
          r_cnt <= '0;
          r_bits <= '0;
          r_state <= bus.write_reset ? RST : SHIFT;
          r_scan_reset <= bus.write_reset;
          r_scan_en <= !bus.write_reset;
          r_scan_in <= bus.write_reset ? 1'b0 : bus.write_payload[PAYLOAD_W-1];
        end
        RST: if (w_tick) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == 2'd3) begin
            r_state <= SHIFT;
            r_scan_reset <= 1'b0;
            r_scan_en <= 1'b1;
            r_scan_in <= r_frame[FRAME_W-1];
          end
        end
        SHIFT: if (w_tick) begin
          r_cnt <= r_cnt + 1'b1;
          r_scan_clk <= !r_cnt[0];
          // new data is only presented on the tick that drops scan_clk
          if (r_cnt[0] && r_bits == 8'(FRAME_W - 1)) begin
            r_state <= UPDATE;
            r_cnt <= '0;
            r_scan_en <= 1'b0;
            r_scan_update <= 1'b1;
          end else if (r_cnt[0]) begin
            r_bits <= r_bits + 1'b1;
            r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
            r_scan_in <= r_frame[FRAME_W-2];
          end
        end
        UPDATE: if (w_tick) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == 2'd1) begin
            r_state <= IDLE;
            r_scan_update <= 1'b0;
            r_scan_in <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scanchain_writer.sv
// tb_scanchain_writer: vector table, corner sequences and random writes checked against a frame/latency model
module tb_scanchain_writer;
  localparam int AW = 12;
  localparam int PW = 169;
  localparam int FW = AW + PW;
  localparam int HALF = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scan_clk, scan_en, scan_in, scan_update, scan_reset;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [AW-1:0] a;
    logic [PW-1:0] p;
    logic          r;
    int            lat;
  } vec_t;
  vec_t tbl[4];
  scanchain_writer_if #(.ADDR_W(AW), .PAYLOAD_W(PW)) bus ();
  scanchain_writer #(
    .CLOCK_FREQ(20),
    .SCAN_CLK_FREQ(5),
    .ADDR_W(AW),
    .PAYLOAD_W(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .scan_clk(scan_clk),
    .scan_en(scan_en),
    .scan_in(scan_in),
    .scan_update(scan_update),
    .scan_reset(scan_reset)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  function automatic logic [PW-1:0] rand_payload();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction
  task automatic send(input logic [AW-1:0] a, input logic [PW-1:0] p, input logic r, input int lat,
                      input bit intf, input logic [AW-1:0] ia, input logic [PW-1:0] ip);
    logic [FW-1:0] got = '0;
    int nbits = 0, updc = 0, updp = 0, rstc = 0, bad = 0, cyc = 0;
    logic pclk = 1'b0, pin = 1'b0, pupd = 1'b0;
    bit en_seen = 1'b0;
    chk("ready_before", bus.write_ready, 1);
    bus.write_valid = 1'b1;
    bus.write_addr = a;
    bus.write_payload = p;
    bus.write_reset = r;
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.write_valid = 1'b0;
        bus.write_addr = ~a;
        bus.write_payload = ~p;
        bus.write_reset = ~r;
        chk("accepted", bus.write_ready, 0);
      end
      if (intf && cyc == 300) begin
        bus.write_valid = 1'b1;
        bus.write_addr = ia;
        bus.write_payload = ip;
        bus.write_reset = 1'b0;
      end
      if (!pclk && scan_clk) begin
        got = {got[FW-2:0], scan_in};
        nbits++;
      end
      if (pclk && scan_clk && scan_in !== pin) bad++;
      if (scan_clk && !scan_en) bad++;
      if (scan_en) en_seen = 1'b1;
      if (scan_reset && !en_seen) rstc++;
      if (scan_reset && (scan_en || scan_clk)) bad++;
      if (scan_update) updc++;
      if (scan_update && !pupd) updp++;
      if (scan_update && scan_en) bad++;
      pclk = scan_clk;
      pin = scan_in;
      pupd = scan_update;
      if (bus.write_ready || cyc >= 2000) break;
      @(posedge clk);
      cyc++;
    end
    chk("frame", got, {p, a});
    chk("bit_count", nbits, FW);
    chk("update_cycles", updc, 4);
    chk("update_pulses", updp, 1);
    chk("reset_cycles", rstc, r ? 8 : 0);
    chk("latency", cyc, lat);
    chk("glitches", bad, 0);
    chk("idle_outputs", {scan_clk, scan_en, scan_in, scan_update, scan_reset}, 0);
  endtask
  initial begin
    logic [PW-1:0] p1, p2;
    int n, cyc;
    logic pc;
    bit r;
    tbl[0] = '{12'hA5C, (PW'(1) << (PW - 1)) | PW'(1), 1'b0, 728};
    tbl[1] = '{12'hA5C, (PW'(1) << (PW - 1)) | PW'(1), 1'b1, 736};
    tbl[2] = '{12'hFFF, '1, 1'b0, 728};
    tbl[3] = '{12'h000, PW'({85{2'b10}}), 1'b1, 736};
    bus.write_valid = 1'b0;
    bus.write_addr = '0;
    bus.write_payload = '0;
    bus.write_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("reset_idle", {bus.write_ready, scan_clk, scan_en, scan_in, scan_update, scan_reset}, 6'b100000);
    end
    for (int i = 0; i < 4; i++) send(tbl[i].a, tbl[i].p, tbl[i].r, tbl[i].lat, 1'b0, '0, '0);
    p1 = rand_payload();
    p2 = rand_payload();
    send(12'h3C3, p1, 1'b0, 728, 1'b1, 12'h5A5, p2);
    send(12'h5A5, p2, 1'b0, 728, 1'b0, '0, '0);
    @(negedge clk);
    bus.write_valid = 1'b1;
    bus.write_addr = 12'h123;
    bus.write_payload = p1;
    bus.write_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.write_valid = 1'b0;
    n = 0;
    cyc = 0;
    pc = 1'b0;
    while (n < 90 && cyc < 1500) begin
      @(negedge clk);
      if (!pc && scan_clk) n++;
      pc = scan_clk;
      cyc++;
    end
    chk("bits_before_abort", n, 90);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outputs", {bus.write_ready, scan_clk, scan_en, scan_in, scan_update, scan_reset}, 6'b100000);
    @(negedge clk);
    reset = 1'b0;
    send(12'hBEE, p2, 1'b0, 728, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      r = 1'($urandom_range(0, 1));
      send(AW'($urandom), rand_payload(), r, (2 * FW + 2 + 4 * int'(r)) * HALF, 1'b0, '0, '0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
